// File: rtl/pixel_stream_packer_if.sv
// Pixel-in / packed-word-out bus for pixel_stream_packer.
// Handshake: a word transfers on every rising clk edge where word_out_valid && word_out_ready; while valid is high and ready low, word_out and its flags hold steady; valid never waits on ready.
interface pixel_stream_packer_if #(
  parameter int PIX_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16
);
  localparam int WORD_W = PIX_W * PACK;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  logic [PIX_W-1:0]  pixel_in;
  logic              pixel_in_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_out_valid;
  logic              word_out_ready;
  logic              word_out_sof;
  logic              word_out_eol;
  logic              word_out_eof;
  logic              frame_done;
  logic              overflow;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    input  pixel_in, pixel_in_valid, word_out_ready,
    output word_out, word_out_valid, word_out_sof, word_out_eol, word_out_eof,
    output frame_done, overflow, fifo_level
  );

  modport slave (
    output pixel_in, pixel_in_valid, word_out_ready,
    input  word_out, word_out_valid, word_out_sof, word_out_eol, word_out_eof,
    input  frame_done, overflow, fifo_level
  );
endinterface

// File: rtl/pixel_stream_packer.sv
// Packs raster pixels into words, tags them with frame/line flags and buffers them in a
// first-word-fall-through FIFO; words arriving at a full FIFO are dropped and flagged.
module pixel_stream_packer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int PIX_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic rstN,
  pixel_stream_packer_if.master bus
);
  localparam int WORD_W = PIX_W * PACK;
  localparam int ENT_W  = WORD_W + 3;
  localparam int COLS   = IMG_WIDTH / PACK;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] pack_q, word_d;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              overflow_q, frame_done_q;
  logic              push, pop, accept, full, empty, last_col, last_row;
  logic              sof_d, eol_d, eof_d;
  logic [ENT_W-1:0]  head;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    push     = bus.pixel_in_valid && (cnt_q == CNT_W'(PACK - 1));
    pop      = !empty && bus.word_out_ready;
    // A full FIFO still takes the new word when the head leaves on the same edge.
    accept   = push && (!full || pop);
    last_col = (col_q == COL_W'(COLS - 1));
    last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
    sof_d    = (col_q == '0) && (row_q == '0);
    eol_d    = last_col;
    eof_d    = last_col && last_row;
    word_d   = pack_q;
    word_d[(PACK-1)*PIX_W +: PIX_W] = bus.pixel_in;
    level_d  = level_q;
    if (accept && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!accept && pop) begin
      level_d = level_q - LVL_W'(1);
    end
    head = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rstN && accept) begin
      mem_q[wr_ptr_q] <= {eof_d, eol_d, sof_d, word_d};
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      pack_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.pixel_in_valid) begin
        cnt_q <= push ? '0 : cnt_q + CNT_W'(1);
        pack_q[cnt_q*PIX_W +: PIX_W] <= bus.pixel_in;
      end
      // Framing advances even for dropped words so later flags stay aligned to the raster.
      if (push) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (push && !accept) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q      <= level_d;
      frame_done_q <= pop && head[ENT_W-1];
    end
  end

  // Head contents are masked when empty so stale storage never shows after reset.
  assign bus.word_out       = empty ? '0 : head[WORD_W-1:0];
  assign bus.word_out_valid = !empty;
  assign bus.word_out_sof   = !empty && head[WORD_W];
  assign bus.word_out_eol   = !empty && head[WORD_W+1];
  assign bus.word_out_eof   = !empty && head[WORD_W+2];
  assign bus.frame_done     = frame_done_q;
  assign bus.overflow       = overflow_q;
  assign bus.fifo_level     = level_q;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Randomized and directed bench for pixel_stream_packer on a 8x2 frame with a 4-deep FIFO,
// checked every cycle against a queue-based model of the packing/framing rules.
module tb_pixel_stream_packer;
  localparam int IMG_WIDTH   = 8;
  localparam int IMG_HEIGHT  = 2;
  localparam int PIX_W       = 8;
  localparam int PACK        = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int WORD_W      = PIX_W * PACK;
  localparam int ENT_W       = WORD_W + 3;
  localparam int COLS        = IMG_WIDTH / PACK;
  localparam int FRAME_WORDS = COLS * IMG_HEIGHT;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pixel_stream_packer_if #(.PIX_W(PIX_W), .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  pixel_stream_packer #(
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .PIX_W(PIX_W),
    .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries are {eof, eol, sof, word}.
  logic [ENT_W-1:0] exp_q[$];
  logic [PIX_W-1:0] grp_q[$];
  int unsigned      word_idx;
  logic             m_ovf = 1'b0;
  logic             m_fd  = 1'b0;
  logic             model_live = 1'b0;

  always @(posedge clk) begin : model_blk
    logic             do_pop;
    logic             popped_eof;
    logic [WORD_W-1:0] w;
    int unsigned      pos;
    logic             sof, eol, eof;
    if (rstN) begin
      exp_q.delete();
      grp_q.delete();
      word_idx   = 0;
      m_ovf      = 1'b0;
      m_fd       = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      do_pop     = bus.word_out_ready && (exp_q.size() != 0);
      popped_eof = do_pop && exp_q[0][ENT_W-1];
      if (do_pop) void'(exp_q.pop_front());
      if (bus.pixel_in_valid) begin
        grp_q.push_back(bus.pixel_in);
        if (grp_q.size() == PACK) begin
          w = '0;
          for (int i = 0; i < PACK; i++) w[i*PIX_W +: PIX_W] = grp_q[i];
          grp_q.delete();
          pos = word_idx % FRAME_WORDS;
          sof = (pos == 0);
          eol = ((pos % COLS) == COLS - 1);
          eof = (pos == FRAME_WORDS - 1);
          word_idx++;
          if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({eof, eol, sof, w});
          else m_ovf = 1'b1;
        end
      end
      m_fd = popped_eof;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [ENT_W-1:0] got_q[$];
  int               fd_count = 0;

  always @(negedge clk) begin
    if (model_live) begin
      chk("valid", bus.word_out_valid, exp_q.size() != 0);
      chk("fifo_level", bus.fifo_level, exp_q.size());
      chk("overflow", bus.overflow, m_ovf);
      chk("frame_done", bus.frame_done, m_fd);
      if (exp_q.size() != 0) begin
        chk("word_out", bus.word_out, exp_q[0][WORD_W-1:0]);
        chk("flags", {bus.word_out_eof, bus.word_out_eol, bus.word_out_sof}, exp_q[0][ENT_W-1:WORD_W]);
      end
      if (bus.word_out_valid && bus.word_out_ready)
        got_q.push_back({bus.word_out_eof, bus.word_out_eol, bus.word_out_sof, bus.word_out});
      if (bus.frame_done) fd_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [PIX_W-1:0] p, input logic r);
    @(posedge clk);
    #2;
    bus.pixel_in_valid = v;
    bus.pixel_in       = p;
    bus.word_out_ready = r;
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      rstN               = 1'b1;
      bus.pixel_in_valid = 1'b1;
      bus.pixel_in       = PIX_W'($urandom);
      bus.word_out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #2;
    rstN               = 1'b0;
    bus.pixel_in_valid = 1'b0;
    bus.word_out_ready = 1'b0;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) drive(1'b0, '0, r);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [ENT_W-1:0] frame_tbl [FRAME_WORDS];
  int               bias;

  initial begin
    frame_tbl[0] = {3'b001, 32'h03020100};
    frame_tbl[1] = {3'b010, 32'h07060504};
    frame_tbl[2] = {3'b000, 32'h0B0A0908};
    frame_tbl[3] = {3'b110, 32'h0F0E0D0C};
    bus.pixel_in       = '0;
    bus.pixel_in_valid = 1'b1;
    bus.word_out_ready = 1'b0;

    // Reset held 3 cycles with pixels arriving.
    do_reset(3);
    chk("rst_valid", bus.word_out_valid, 1'b0);
    chk("rst_level", bus.fifo_level, 3'd0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_word", bus.word_out, 32'h0);

    // Single word, visible exactly one cycle with ready high.
    drive(1'b1, 8'h11, 1'b1);
    drive(1'b1, 8'h22, 1'b1);
    drive(1'b1, 8'h33, 1'b1);
    drive(1'b1, 8'h44, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("single_valid", bus.word_out_valid, 1'b1);
    chk("single_word", bus.word_out, 32'h44332211);
    chk("single_flags", {bus.word_out_eof, bus.word_out_eol, bus.word_out_sof}, 3'b001);
    drive(1'b0, '0, 1'b1);
    chk("single_gone", bus.word_out_valid, 1'b0);

    // Full frame then the first word of the next frame.
    do_reset(1);
    got_q.delete();
    fd_count = 0;
    for (int i = 0; i < 16; i++) drive(1'b1, PIX_W'(i), 1'b1);
    idle(4, 1'b1);
    chk("frame_count", got_q.size(), 4);
    for (int i = 0; i < FRAME_WORDS; i++)
      if (i < got_q.size()) chk("frame_word", got_q[i], frame_tbl[i]);
    chk("frame_done_pulses", fd_count, 1);
    for (int i = 16; i < 20; i++) drive(1'b1, PIX_W'(i), 1'b1);
    idle(3, 1'b1);
    chk("next_frame_count", got_q.size(), 5);
    if (got_q.size() > 4) chk("next_frame_sof", got_q[4], {3'b001, 32'h13121110});

    // Gapped input gives the same words.
    do_reset(1);
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, PIX_W'(i), 1'b1);
      drive(1'b0, 8'hEE, 1'b1);
    end
    idle(3, 1'b1);
    chk("gap_count", got_q.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < got_q.size()) chk("gap_word", got_q[i], frame_tbl[i]);

    // Overflow: fifth word dropped, framing keeps counting.
    do_reset(1);
    got_q.delete();
    for (int i = 0; i < 16; i++) drive(1'b1, PIX_W'(i), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("ovf_level_full", bus.fifo_level, 3'd4);
    chk("ovf_not_yet", bus.overflow, 1'b0);
    for (int i = 16; i < 20; i++) drive(1'b1, PIX_W'(i), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("ovf_level_hold", bus.fifo_level, 3'd4);
    chk("ovf_set", bus.overflow, 1'b1);
    idle(6, 1'b1);
    chk("ovf_drain_count", got_q.size(), 4);
    for (int i = 0; i < FRAME_WORDS; i++)
      if (i < got_q.size()) chk("ovf_drain_word", got_q[i], frame_tbl[i]);
    chk("ovf_sticky", bus.overflow, 1'b1);
    for (int i = 20; i < 24; i++) drive(1'b1, PIX_W'(i), 1'b1);
    idle(3, 1'b1);
    chk("ovf_after_count", got_q.size(), 5);
    if (got_q.size() > 4) chk("ovf_after_flags", got_q[4], {3'b010, 32'h17161514});

    // Full FIFO with push and pop on the same edge.
    do_reset(1);
    for (int i = 0; i < 19; i++) drive(1'b1, PIX_W'(i), 1'b0);
    drive(1'b1, 8'd19, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("pp_level", bus.fifo_level, 3'd4);
    chk("pp_overflow", bus.overflow, 1'b0);
    chk("pp_head", bus.word_out, 32'h07060504);
    idle(6, 1'b1);

    // Reset in the middle of a group discards the partial pixels.
    do_reset(1);
    drive(1'b1, 8'h55, 1'b1);
    drive(1'b1, 8'h66, 1'b1);
    do_reset(1);
    got_q.delete();
    drive(1'b1, 8'hA1, 1'b1);
    drive(1'b1, 8'hA2, 1'b1);
    drive(1'b1, 8'hA3, 1'b1);
    drive(1'b1, 8'hA4, 1'b1);
    idle(3, 1'b1);
    chk("midrst_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("midrst_word", got_q[0], {3'b001, 32'hA4A3A2A1});

    // Random traffic with varying consumer pressure and rare resets.
    do_reset(1);
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) bias = $urandom_range(10, 100);
      if ($urandom_range(0, 999) == 0) begin
        do_reset(1);
      end else begin
        drive(1'($urandom_range(0, 3) != 0), PIX_W'($urandom),
              1'($urandom_range(1, 100) <= bias));
      end
    end
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Sink end of the serial pixel stream (`pixel_in`/`pixel_in_valid`) used between pipeline stages such as the gaussian and gradient outputs.
- Packs consecutive 8-bit pixels into 32-bit words and buffers them in a FIFO.
- Emits the words over a valid/ready interface with raster framing flags (start-of-frame, end-of-line, end-of-frame).
- Upstream has no backpressure, so FIFO overflow is detected and flagged rather than stalling the source.

Parameters:
- IMG_WIDTH, 512, pixels per line; must be a multiple of PACK.
- IMG_HEIGHT, 512, lines per frame.
- PIX_W, 8, bits per pixel.
- PACK, 4, pixels per output word; word width = PIX_W*PACK.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstN  in  1  synchronous reset, active-high (1 = reset), despite the name.
- pixel_in  in  PIX_W  pixel in raster order.
- pixel_in_valid  in  1  pixel_in is sampled on every edge where this is high; gaps allowed.
- word_out  out  PIX_W*PACK  packed word; first pixel of the group in bits [PIX_W-1:0].
- word_out_valid  out  1  FIFO head valid.
- word_out_ready  in  1  consumer accepts the word when valid && ready.
- word_out_sof  out  1  head word is the first word of a frame.
- word_out_eol  out  1  head word is the last word of a line.
- word_out_eof  out  1  head word is the last word of a frame.
- frame_done  out  1  one-cycle pulse on the cycle after the eof word is popped.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: when rstN=1 at an edge:
  - FIFO is flushed, pack register and pack count are cleared, col/row counters are cleared, overflow is cleared.
  - All outputs read 0 after that edge.
  - pixel_in is ignored in any cycle where rstN=1.
- Packing:
  - A pack counter (0..PACK-1) advances on each accepted pixel.
  - The accepted pixel goes into lane = pack count.
  - On the PACK-th pixel, the assembled word (prior lanes plus the current pixel_in) is pushed on that same edge.
- Framing counters:
  - Column word index 0..IMG_WIDTH/PACK-1 and row index 0..IMG_HEIGHT-1, advanced per pushed (or dropped) word.
  - Flags are stored alongside each word:
    - sof = row 0 and col 0.
    - eol = last col.
    - eof = last col and last row.
  - After the eof word, counters wrap to row 0, col 0.
- Latency: a word is visible on word_out_valid after the same edge that samples its PACK-th pixel (FIFO is first-word-fall-through). Total latency is 1 cycle from that edge.
- Pop: occurs when word_out_valid && word_out_ready. The next entry, if any, appears after the edge.
- Output stability: word_out and all flags are stable while valid && !ready.
- FIFO full and push with no pop:
  - The word is dropped and overflow is set (sticky until reset).
  - Framing counters still advance, so later words keep correct sof/eol/eof.
  - fifo_level stays at FIFO_DEPTH.
- FIFO full with simultaneous push and pop: the push is accepted, there is no overflow, and the level is unchanged.
- FIFO empty with a push and ready=1: the word is presented next cycle; there is no bypass within the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_level.
- frame_done: pulses 1 cycle after the pop of a word with eof=1, independent of overflow.
- Partial group or frame: there is no timeout; the pack register holds until more pixels arrive or reset.

Test Plan:
- Reset: hold rstN=1 for 3 cycles with pixel_in_valid=1 -> word_out_valid=0, fifo_level=0, overflow=0, frame_done=0, and no words are produced afterwards from reset-cycle pixels.
- Single word: with ready=1, send pixels 0x11,0x22,0x33,0x44 on consecutive cycles -> word_out=0x44332211 with sof=1, eol=0, eof=0, valid high for exactly 1 cycle, starting after the 4th pixel's edge.
- Full frame, small config (IMG_WIDTH=8, IMG_HEIGHT=2), ready=1, 16 pixels valued 0..15:
  - Produces 4 words: 0x03020100 (sof), 0x07060504 (eol), 0x0B0A0908, 0x0F0E0D0C (eol, eof).
  - frame_done pulses once.
  - The next frame's first word has sof=1.
- Gapped input: valid toggles 1/0 over 8 pixels -> same 2 words and values as gap-free input.
- Overflow (FIFO_DEPTH=4), ready=0, 20 pixels:
  - fifo_level reaches 4, the 5th word is dropped, overflow=1.
  - Then ready=1 -> the first 4 words drain in order, and flags match their original positions.
- Full FIFO with push and pop in the same cycle -> level stays 4 and overflow stays 0.
- Reset mid-group: 2 pixels, then reset, then 0xA1..0xA4 -> single word 0xA4A3A2A1 with sof=1.
